// File: rtl/output_port_sched.sv
// Output-port scheduler: LRS matrix arbiter with wormhole lock and per-VC credits.
// Ports: req/req_vc/req_tail in, credit_in in; gnt/gnt_vc/locked/owner/credit_cnt/cred_err out.
module output_port_sched #(
  parameter  int REQS    = 5,
  parameter  int VCS     = 2,
  parameter  int CREDITS = 4,
  localparam int VW = (VCS > 1) ? $clog2(VCS) : 1,
  localparam int CW = $clog2(CREDITS + 1),
  localparam int OW = (REQS > 1) ? $clog2(REQS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REQS-1:0]     req,
  input  logic [REQS*VW-1:0]  req_vc,
  input  logic [REQS-1:0]     req_tail,
  input  logic [VCS-1:0]      credit_in,
  output logic [REQS-1:0]     gnt,
  output logic [VW-1:0]       gnt_vc,
  output logic                locked,
  output logic [OW-1:0]       owner,
  output logic [VCS*CW-1:0]   credit_cnt,
  output logic                cred_err
);

  logic [REQS-1:0][REQS-1:0] prio_q, prio_d;
  logic                      locked_q, locked_d;
  logic [OW-1:0]             owner_q, owner_d;
  logic [VW-1:0]             lvc_q, lvc_d;
  logic [VCS-1:0][CW-1:0]    cnt_q, cnt_d;
  logic                      err_q, err_d;

  logic [REQS-1:0][VW-1:0]   vc_sel;
  logic [REQS-1:0]           elig;
  logic [REQS-1:0]           win;
  logic [OW-1:0]             widx;
  logic [VW-1:0]             wvc;
  logic                      wtail;
  logic [VCS-1:0]            vc_dec;

  // While locked every requester looks at the locked VC, but only
  // the owner can become eligible.
  always_comb begin
    vc_sel = '0;
    elig   = '0;
    for (int i = 0; i < REQS; i++) begin
      vc_sel[i] = locked_q ? lvc_q : req_vc[i*VW +: VW];
      elig[i]   = req[i] && (cnt_q[vc_sel[i]] != '0) &&
                  (!locked_q || owner_q == OW'(i));
    end
  end

  always_comb begin
    win   = '0;
    widx  = '0;
    wvc   = '0;
    wtail = 1'b0;
    for (int i = 0; i < REQS; i++) begin
      win[i] = elig[i];
      for (int j = 0; j < REQS; j++) begin
        if (j != i && elig[j] && prio_q[j][i]) win[i] = 1'b0;
      end
    end
    for (int i = 0; i < REQS; i++) begin
      if (win[i]) begin
        widx  = OW'(i);
        wvc   = vc_sel[i];
        wtail = req_tail[i];
      end
    end
  end

  always_comb begin
    vc_dec = '0;
    for (int v = 0; v < VCS; v++) begin
      vc_dec[v] = (|win) && (wvc == VW'(v));
    end
  end

  always_comb begin
    prio_d   = prio_q;
    locked_d = locked_q;
    owner_d  = owner_q;
    lvc_d    = lvc_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (|win) begin
      if (!locked_q) begin
        // Winner drops to lowest priority.
        for (int i = 0; i < REQS; i++) begin
          if (win[i]) begin
            for (int j = 0; j < REQS; j++) begin
              if (j != i) begin
                prio_d[i][j] = 1'b0;
                prio_d[j][i] = 1'b1;
              end
            end
          end
        end
        if (!wtail) begin
          locked_d = 1'b1;
          owner_d  = widx;
          lvc_d    = wvc;
        end
      end else if (wtail) begin
        locked_d = 1'b0;
        owner_d  = '0;
        lvc_d    = '0;
      end
    end
    for (int v = 0; v < VCS; v++) begin
      if (credit_in[v] && !vc_dec[v]) begin
        if (cnt_q[v] == CW'(CREDITS)) err_d = 1'b1;
        else cnt_d[v] = cnt_q[v] + CW'(1);
      end else if (vc_dec[v] && !credit_in[v]) begin
        cnt_d[v] = cnt_q[v] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REQS; i++) begin
        for (int j = 0; j < REQS; j++) begin
          prio_q[i][j] <= (i < j);
        end
      end
      locked_q <= 1'b0;
      owner_q  <= '0;
      lvc_q    <= '0;
      for (int v = 0; v < VCS; v++) begin
        cnt_q[v] <= CW'(CREDITS);
      end
      err_q    <= 1'b0;
    end else begin
      prio_q   <= prio_d;
      locked_q <= locked_d;
      owner_q  <= owner_d;
      lvc_q    <= lvc_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign gnt        = win;
  assign gnt_vc     = wvc;
  assign locked     = locked_q;
  assign owner      = owner_q;
  assign credit_cnt = cnt_q;
  assign cred_err   = err_q;

endmodule

// File: tb/tb_output_port_sched.sv
// Directed bench for output_port_sched: arbitration order, wormhole lock,
// credit gating, sticky credit error and mid-packet async reset.
module tb_output_port_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] req = '0;
  logic [4:0] req_vc = '0;
  logic [4:0] req_tail = '0;
  logic [1:0] credit_in = '0;
  logic [4:0] gnt;
  logic [0:0] gnt_vc;
  logic       locked;
  logic [2:0] owner;
  logic [5:0] credit_cnt;
  logic       cred_err;

  int checks = 0;
  int failures = 0;

  output_port_sched dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_vc     (req_vc),
    .req_tail   (req_tail),
    .credit_in  (credit_in),
    .gnt        (gnt),
    .gnt_vc     (gnt_vc),
    .locked     (locked),
    .owner      (owner),
    .credit_cnt (credit_cnt),
    .cred_err   (cred_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive at falling edge, settle, then caller checks.
  task automatic drv(input logic [4:0] r,
                     input logic [4:0] v,
                     input logic [4:0] t,
                     input logic [1:0] c);
    @(negedge clk);
    req = r;
    req_vc = v;
    req_tail = t;
    credit_in = c;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0;
    req_vc = '0;
    req_tail = '0;
    credit_in = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  logic [4:0] exp_a [6];

  initial begin
    exp_a[0] = 5'b00010; exp_a[1] = 5'b00100; exp_a[2] = 5'b10000;
    exp_a[3] = 5'b00010; exp_a[4] = 5'b00100; exp_a[5] = 5'b10000;

    // Reset state
    do_reset();
    #1;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_cnt", 32'(credit_cnt), 32'o44);
    chk("rst_err", 32'(cred_err), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);

    // Round robin of single-flit packets with matching credit return
    for (int k = 0; k < 6; k++) begin
      drv(5'b10110, 5'b00000, 5'b11111, 2'b01);
      chk("rr_gnt", 32'(gnt), 32'(exp_a[k]));
      chk("rr_cnt", 32'(credit_cnt), 32'o44);
    end
    drv('0, '0, '0, '0);
    chk("rr_cnt_end", 32'(credit_cnt), 32'o44);
    chk("rr_err", 32'(cred_err), 32'd0);

    // 4-flit packet from requester 3 on VC1, requester 0 waiting
    do_reset();
    drv(5'b01000, 5'b01000, 5'b00000, 2'b00);
    chk("pk_head", 32'(gnt), 32'b01000);
    chk("pk_head_vc", 32'(gnt_vc), 32'd1);
    chk("pk_unlocked", 32'(locked), 32'd0);
    drv(5'b01001, 5'b01000, 5'b00000, 2'b00);
    chk("pk_body1", 32'(gnt), 32'b01000);
    chk("pk_locked", 32'(locked), 32'd1);
    chk("pk_owner", 32'(owner), 32'd3);
    drv(5'b01001, 5'b01000, 5'b00000, 2'b00);
    chk("pk_body2", 32'(gnt), 32'b01000);
    drv(5'b01001, 5'b01000, 5'b01000, 2'b00);
    chk("pk_tail", 32'(gnt), 32'b01000);
    chk("pk_tail_lock", 32'(locked), 32'd1);
    drv(5'b00001, 5'b00000, 5'b00001, 2'b00);
    chk("pk_next", 32'(gnt), 32'b00001);
    chk("pk_next_vc", 32'(gnt_vc), 32'd0);
    chk("pk_unlock", 32'(locked), 32'd0);
    chk("pk_owner0", 32'(owner), 32'd0);
    chk("pk_cnt", 32'(credit_cnt), 32'o04);

    // Credit exhaustion on VC0, VC1 still served
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drv(5'b00001, 5'b00000, 5'b00001, 2'b00);
      chk("cr_gnt", 32'(gnt), 32'b00001);
      chk("cr_cnt", 32'(credit_cnt[2:0]), 32'(4 - k));
    end
    drv(5'b00001, 5'b00000, 5'b00001, 2'b00);
    chk("cr_block", 32'(gnt), 32'd0);
    chk("cr_cnt0", 32'(credit_cnt), 32'o40);
    drv(5'b00011, 5'b00010, 5'b00011, 2'b00);
    chk("cr_vc1_gnt", 32'(gnt), 32'b00010);
    chk("cr_vc1_vc", 32'(gnt_vc), 32'd1);
    drv('0, '0, '0, '0);
    chk("cr_cnt_vc1", 32'(credit_cnt), 32'o30);

    // Locked owner bubbles
    do_reset();
    drv(5'b00100, 5'b00000, 5'b00000, 2'b00);
    chk("bb_head", 32'(gnt), 32'b00100);
    drv(5'b00101, 5'b00000, 5'b00000, 2'b00);
    chk("bb_body", 32'(gnt), 32'b00100);
    chk("bb_owner", 32'(owner), 32'd2);
    drv(5'b00001, 5'b00000, 5'b00001, 2'b00);
    chk("bb_gap1", 32'(gnt), 32'd0);
    chk("bb_lock1", 32'(locked), 32'd1);
    drv(5'b00001, 5'b00000, 5'b00001, 2'b00);
    chk("bb_gap2", 32'(gnt), 32'd0);
    chk("bb_lock2", 32'(locked), 32'd1);
    chk("bb_owner2", 32'(owner), 32'd2);
    drv(5'b00101, 5'b00000, 5'b00101, 2'b00);
    chk("bb_tail", 32'(gnt), 32'b00100);
    drv(5'b00001, 5'b00000, 5'b00001, 2'b00);
    chk("bb_after", 32'(gnt), 32'b00001);
    chk("bb_unlock", 32'(locked), 32'd0);
    chk("bb_cnt", 32'(credit_cnt), 32'o41);

    // Credit returned to a full counter
    do_reset();
    drv('0, '0, '0, 2'b01);
    chk("ce_pre", 32'(cred_err), 32'd0);
    drv('0, '0, '0, 2'b00);
    chk("ce_set", 32'(cred_err), 32'd1);
    chk("ce_cnt", 32'(credit_cnt), 32'o44);
    drv(5'b00001, 5'b00000, 5'b00001, 2'b00);
    drv('0, '0, '0, 2'b01);
    chk("ce_sticky", 32'(cred_err), 32'd1);
    chk("ce_cnt3", 32'(credit_cnt), 32'o43);
    drv('0, '0, '0, 2'b00);
    chk("ce_cnt_back", 32'(credit_cnt), 32'o44);
    chk("ce_sticky2", 32'(cred_err), 32'd1);

    // Async reset mid-packet
    do_reset();
    drv(5'b10000, 5'b10000, 5'b00000, 2'b01);
    chk("mr_head", 32'(gnt), 32'b10000);
    drv(5'b10000, 5'b10000, 5'b00000, 2'b00);
    chk("mr_body", 32'(gnt), 32'b10000);
    chk("mr_err", 32'(cred_err), 32'd1);
    drv(5'b10000, 5'b10000, 5'b00000, 2'b00);
    drv('0, '0, '0, '0);
    chk("mr_cnt", 32'(credit_cnt), 32'o14);
    chk("mr_owner", 32'(owner), 32'd4);
    chk("mr_locked", 32'(locked), 32'd1);
    rst = 1'b0;
    #1;
    chk("mr_rst_locked", 32'(locked), 32'd0);
    chk("mr_rst_owner", 32'(owner), 32'd0);
    chk("mr_rst_cnt", 32'(credit_cnt), 32'o44);
    chk("mr_rst_err", 32'(cred_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drv(5'b11111, 5'b00000, 5'b11111, 2'b00);
    chk("mr_prio", 32'(gnt), 32'b00001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
